// File: rtl/pipe_ctrl_unit.sv
// Pipeline controller for the RV32I pipeline: per-stage load enables and valid bits,
// the instruction-fetch handshake (request / held buffer / wrong-path squash), and stall/flush counters.
module pipe_ctrl_unit #(
    parameter int NUM_STAGES     = 5,
    parameter int HAZARD_STAGE   = 1,
    parameter int REDIRECT_STAGE = 2,
    parameter int CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_resp,
    input  logic                  dmem_busy,
    input  logic                  load_use,
    input  logic                  redirect,
    output logic                  imem_req,
    output logic                  ifbuf_ld,
    output logic                  fetch_sel,
    output logic [NUM_STAGES-1:0] stage_ld,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    typedef enum logic [1:0] {
        F_REQ    = 2'd0,
        F_HELD   = 2'd1,
        F_SQUASH = 2'd2
    } fetch_state_e;

    fetch_state_e              state_q, state_d;
    logic [NUM_STAGES-1:1]     valid_q, valid_d;
    logic [NUM_STAGES-1:0]     cur_valid;
    logic                      red, lu, hold, eff_red, acc;

    // Stage 0 always holds the PC, so only the downstream valid bits are stored.
    assign cur_valid   = {valid_q, 1'b1};
    assign stage_valid = rst ? '0 : cur_valid;

    assign red     = redirect & stage_valid[REDIRECT_STAGE];
    assign lu      = load_use & stage_valid[HAZARD_STAGE];
    assign hold    = dmem_busy | (lu & ~red);
    assign eff_red = red & ~dmem_busy;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        acc       = 1'b0;
        ifbuf_ld  = 1'b0;
        imem_req  = 1'b0;
        fetch_sel = 1'b0;
        if (!rst) begin
            case (state_q)
                F_REQ: begin
                    imem_req = 1'b1;
                    if (imem_resp) begin
                        // A response arriving with a redirect is wrong-path and simply dropped.
                        if (!eff_red) begin
                            if (hold) begin
                                ifbuf_ld = 1'b1;
                                state_d  = F_HELD;
                            end else begin
                                acc = 1'b1;
                            end
                        end
                    end else if (eff_red) begin
                        state_d = F_SQUASH;
                    end
                end
                F_HELD: begin
                    fetch_sel = 1'b1;
                    if (eff_red) begin
                        state_d = F_REQ;
                    end else if (!hold) begin
                        acc     = 1'b1;
                        state_d = F_REQ;
                    end
                end
                F_SQUASH: begin
                    imem_req = 1'b1;
                    if (!eff_red && imem_resp) begin
                        state_d = F_REQ;
                    end
                end
                default: state_d = F_REQ;
            endcase
        end
    end

    always_comb begin
        stage_ld = '0;
        valid_d  = valid_q;
        if (rst || dmem_busy) begin
            stage_ld = '0;
        end else if (red) begin
            stage_ld = '1;
            for (int i = 1; i < NUM_STAGES; i++) begin
                valid_d[i] = (i > REDIRECT_STAGE) ? cur_valid[i-1] : 1'b0;
            end
        end else if (lu) begin
            // Stages up to the hazard stage hold; a bubble enters just behind it.
            for (int i = 0; i < NUM_STAGES; i++) begin
                stage_ld[i] = (i > HAZARD_STAGE);
            end
            for (int i = 1; i < NUM_STAGES; i++) begin
                if (i == HAZARD_STAGE + 1) begin
                    valid_d[i] = 1'b0;
                end else if (i > HAZARD_STAGE + 1) begin
                    valid_d[i] = cur_valid[i-1];
                end
            end
        end else begin
            stage_ld = {{(NUM_STAGES-1){1'b1}}, acc};
            for (int i = 1; i < NUM_STAGES; i++) begin
                valid_d[i] = (i == 1) ? acc : cur_valid[i-1];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= F_REQ;
            valid_q      <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            if (!stage_ld[0] && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (eff_red && flush_count != '1) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: a directed vector table, hand-written corner
// sequences, and randomized traffic compared against a shift-register reference model.
module tb_pipe_ctrl_unit;

    localparam int N = 5;
    localparam int H = 1;
    localparam int R = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, imem_resp, dmem_busy, load_use, redirect;
    logic        imem_req, ifbuf_ld, fetch_sel;
    logic [N-1:0] stage_ld, stage_valid;
    logic [31:0] stall_cycles, flush_count;

    logic        imem_req_s, ifbuf_ld_s, fetch_sel_s;
    logic [N-1:0] stage_ld_s, stage_valid_s;
    logic [3:0]  stall_cycles_s, flush_count_s;

    pipe_ctrl_unit #(.NUM_STAGES(N), .HAZARD_STAGE(H), .REDIRECT_STAGE(R), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_busy(dmem_busy),
        .load_use(load_use), .redirect(redirect), .imem_req(imem_req),
        .ifbuf_ld(ifbuf_ld), .fetch_sel(fetch_sel), .stage_ld(stage_ld),
        .stage_valid(stage_valid), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipe_ctrl_unit #(.NUM_STAGES(N), .HAZARD_STAGE(H), .REDIRECT_STAGE(R), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_busy(dmem_busy),
        .load_use(load_use), .redirect(redirect), .imem_req(imem_req_s),
        .ifbuf_ld(ifbuf_ld_s), .fetch_sel(fetch_sel_s), .stage_ld(stage_ld_s),
        .stage_valid(stage_valid_s), .stall_cycles(stall_cycles_s), .flush_count(flush_count_s)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the next rising edge.
    task automatic step(input bit r, input bit resp, input bit busy, input bit lu, input bit rd);
        @(negedge clk);
        rst       = r;
        imem_resp = resp;
        dmem_busy = busy;
        load_use  = lu;
        redirect  = rd;
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit       rst, resp, busy, lu, red;
        logic [4:0] ld, valid;
        bit       req, sel, ifb;
        int       stall, flush;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input bit r, input bit resp, input bit busy, input bit lu, input bit rd,
                                input logic [4:0] ld, input logic [4:0] valid,
                                input bit req, input bit sel, input bit ifb,
                                input int stall, input int flush);
        vec_t v;
        v.rst = r; v.resp = resp; v.busy = busy; v.lu = lu; v.red = rd;
        v.ld = ld; v.valid = valid; v.req = req; v.sel = sel; v.ifb = ifb;
        v.stall = stall; v.flush = flush;
        return v;
    endfunction

    // Reference model: fetch status as two flags, the pipeline as a shift register of valid bits.
    bit         m_buffered, m_squashing;
    logic [4:0] m_valid;
    int         m_stall, m_flush;

    function automatic logic [4:0] low_mask(input int k);
        return 5'((32'd1 << k) - 1);
    endfunction

    task automatic model_reset();
        m_buffered  = 1'b0;
        m_squashing = 1'b0;
        m_valid     = '0;
        m_stall     = 0;
        m_flush     = 0;
    endtask

    task automatic model_check(input bit r, input bit resp, input bit busy, input bit lu_in, input bit rd);
        logic [4:0] cur, shifted, nv, e_ld;
        bit e_req, e_sel, e_ifb, acc, red, lu, hold, eff;
        if (r) begin
            check("rnd_ld_rst", stage_ld, 0);
            check("rnd_valid_rst", stage_valid, 0);
            check("rnd_req_rst", imem_req, 0);
            check("rnd_ifb_rst", ifbuf_ld, 0);
            check("rnd_stall_rst", stall_cycles, m_stall);
            check("rnd_flush_rst", flush_count, m_flush);
            model_reset();
            return;
        end
        cur   = m_valid | 5'b00001;
        red   = rd && cur[R];
        lu    = lu_in && cur[H];
        hold  = busy || (lu && !red);
        eff   = red && !busy;
        e_req = !m_buffered;
        e_sel = m_buffered;
        e_ifb = 1'b0;
        acc   = 1'b0;
        if (m_buffered) begin
            if (eff) m_buffered = 1'b0;
            else if (!hold) begin acc = 1'b1; m_buffered = 1'b0; end
        end else if (m_squashing) begin
            if (!eff && resp) m_squashing = 1'b0;
        end else if (resp) begin
            if (!eff && hold) begin e_ifb = 1'b1; m_buffered = 1'b1; end
            else if (!eff) acc = 1'b1;
        end else if (eff) begin
            m_squashing = 1'b1;
        end
        shifted = cur << 1;
        if (busy) begin
            e_ld = '0;
            nv   = cur;
        end else if (eff) begin
            e_ld = '1;
            nv   = shifted & ~low_mask(R + 1);
        end else if (lu) begin
            e_ld = ~low_mask(H + 1);
            nv   = (shifted & ~low_mask(H + 2)) | (cur & low_mask(H + 1));
        end else begin
            e_ld = {4'b1111, acc};
            nv   = (shifted & 5'b11101) | {3'b000, acc, 1'b0};
        end
        check("rnd_ld", stage_ld, e_ld);
        check("rnd_ifb", ifbuf_ld, e_ifb);
        check("rnd_req", imem_req, e_req);
        check("rnd_sel", fetch_sel, e_sel);
        check("rnd_valid", stage_valid, cur);
        check("rnd_stall", stall_cycles, m_stall);
        check("rnd_flush", flush_count, m_flush);
        if (!e_ld[0]) m_stall++;
        if (eff) m_flush++;
        m_valid = nv;
    endtask

    initial begin
        bit r, resp, busy, lu, rd;
        rst = 1'b1; imem_resp = 1'b0; dmem_busy = 1'b0; load_use = 1'b0; redirect = 1'b0;

        //              rst resp busy lu red  ld        valid     req sel ifb stall flush
        tbl[0]  = mk(1, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 0, 5'b11111, 5'b00001, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 0, 0, 5'b11111, 5'b00011, 1, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0, 5'b11111, 5'b00111, 1, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 0, 0, 0, 5'b11111, 5'b01111, 1, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 0, 0, 5'b11111, 5'b11111, 1, 0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 0, 1, 0, 5'b11100, 5'b11111, 1, 0, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 5'b11111, 5'b11011, 0, 1, 0, 1, 0);
        tbl[9]  = mk(0, 0, 0, 0, 1, 5'b11111, 5'b10111, 1, 0, 0, 1, 0);
        tbl[10] = mk(0, 1, 0, 0, 0, 5'b11110, 5'b01001, 1, 0, 0, 1, 1);
        tbl[11] = mk(0, 1, 1, 0, 0, 5'b00000, 5'b10001, 1, 0, 1, 2, 1);
        tbl[12] = mk(0, 0, 1, 0, 0, 5'b00000, 5'b10001, 0, 1, 0, 3, 1);
        tbl[13] = mk(0, 0, 1, 0, 0, 5'b00000, 5'b10001, 0, 1, 0, 4, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 5'b11111, 5'b10001, 0, 1, 0, 5, 1);
        tbl[15] = mk(0, 1, 0, 0, 0, 5'b11111, 5'b00011, 1, 0, 0, 5, 1);
        tbl[16] = mk(0, 1, 0, 1, 1, 5'b11111, 5'b00111, 1, 0, 0, 5, 1);
        tbl[17] = mk(0, 1, 0, 0, 0, 5'b11111, 5'b01001, 1, 0, 0, 5, 2);
        tbl[18] = mk(1, 1, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 5, 2);
        tbl[19] = mk(0, 0, 0, 0, 0, 5'b11110, 5'b00001, 1, 0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].rst, tbl[i].resp, tbl[i].busy, tbl[i].lu, tbl[i].red);
            check($sformatf("tbl%0d_ld", i), stage_ld, tbl[i].ld);
            check($sformatf("tbl%0d_valid", i), stage_valid, tbl[i].valid);
            check($sformatf("tbl%0d_req", i), imem_req, tbl[i].req);
            check($sformatf("tbl%0d_sel", i), fetch_sel, tbl[i].sel);
            check($sformatf("tbl%0d_ifb", i), ifbuf_ld, tbl[i].ifb);
            check($sformatf("tbl%0d_stall", i), stall_cycles, tbl[i].stall);
            check($sformatf("tbl%0d_flush", i), flush_count, tbl[i].flush);
        end

        // Reset while squashing a wrong-path fetch with a full pipeline.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sq_full", stage_valid, 5'b11111);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("sq_red_ld", stage_ld, 5'b11111);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sq_valid", stage_valid, 5'b11001);
        check("sq_req", imem_req, 1'b1);
        check("sq_flush", flush_count, 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sq_rst_ld", stage_ld, 5'b00000);
        check("sq_rst_req", imem_req, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sq_rst_valid", stage_valid, 5'b00000);
        check("sq_rst_stall", stall_cycles, 0);
        check("sq_rst_flush", flush_count, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sq_after_ld", stage_ld, 5'b11111);
        check("sq_after_sel", fetch_sel, 1'b0);

        // Twenty frozen cycles: the 4-bit counter saturates at 15.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("sat_stall_wide", stall_cycles, 20);
        check("sat_stall_small", stall_cycles_s, 4'd15);
        check("sat_ld_small", stage_ld_s, 5'b00000);

        // Randomized traffic against the reference model.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        for (int i = 0; i < 400; i++) begin
            r    = ($urandom_range(0, 39) == 0);
            resp = ($urandom_range(0, 9) < 6);
            busy = ($urandom_range(0, 9) < 2);
            lu   = ($urandom_range(0, 9) < 2);
            rd   = ($urandom_range(0, 19) < 3);
            step(r, resp, busy, lu, rd);
            model_check(r, resp, busy, lu, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
